// File: rtl/lc4_imem_fill_ctrl.sv
// lc4_imem_fill_ctrl: icache miss handler holding the address for MEM_LATENCY cycles, then issuing a one-cycle fill
module lc4_imem_fill_ctrl #(
  parameter int MEM_LATENCY = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic             miss_req,
  input  logic [15:0]      miss_addr,
  output logic [15:0]      mem_iaddr,
  input  logic [15:0]      mem_idata,
  output logic             fill_valid,
  output logic [15:0]      fill_addr,
  output logic [15:0]      fill_data,
  output logic             busy,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FILL = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       req_addr_q, req_addr_d;
  logic [15:0]       fill_addr_q, fill_addr_d;
  logic [15:0]       fill_data_q, fill_data_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  // state register; gwe freezing is folded into the next-state logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      req_addr_q  <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      req_addr_q  <= req_addr_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end
  // next state: accept from IDLE only, count down the latency, capture the word, then fill
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    req_addr_d  = req_addr_q;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    miss_cnt_d  = miss_cnt_q;
    if (gwe) begin
      case (state_q)
        IDLE: if (miss_req) begin
          req_addr_d = miss_addr;
          count_d    = CW'(MEM_LATENCY - 1);
          miss_cnt_d = (miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
          state_d    = WAIT;
        end
        WAIT: if (count_q != '0) count_d = count_q - CW'(1);
        else begin
          fill_data_d = mem_idata;
          fill_addr_d = req_addr_q;
          state_d     = FILL;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign busy       = state_q != IDLE;
  assign mem_iaddr  = busy ? req_addr_q : '0;
  assign fill_valid = (state_q == FILL) && gwe;
  assign fill_addr  = fill_addr_q;
  assign fill_data  = fill_data_q;
  assign miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_lc4_imem_fill_ctrl.sv
// tb_lc4_imem_fill_ctrl: directed checks of the icache fill controller
module tb_lc4_imem_fill_ctrl;
  logic        clk = 0, rst = 1, gwe = 1, miss_req = 0;
  logic [15:0] miss_addr = '0, mem_idata = '0;
  logic [15:0] mem_iaddr, fill_addr, fill_data, mem_iaddr_s, fill_addr_s, fill_data_s;
  logic        fill_valid, busy, fill_valid_s, busy_s;
  logic [15:0] miss_cnt;
  logic [2:0]  miss_cnt_s;
  int tests = 0, fails = 0, pulses;

  lc4_imem_fill_ctrl dut (
    .clk(clk), .rst(rst), .gwe(gwe), .miss_req(miss_req), .miss_addr(miss_addr),
    .mem_iaddr(mem_iaddr), .mem_idata(mem_idata), .fill_valid(fill_valid),
    .fill_addr(fill_addr), .fill_data(fill_data), .busy(busy), .miss_cnt(miss_cnt));

  lc4_imem_fill_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .gwe(gwe), .miss_req(miss_req), .miss_addr(miss_addr),
    .mem_iaddr(mem_iaddr_s), .mem_idata(mem_idata), .fill_valid(fill_valid_s),
    .fill_addr(fill_addr_s), .fill_data(fill_data_s), .busy(busy_s), .miss_cnt(miss_cnt_s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_iaddr"}, 32'(mem_iaddr), 0);
    chk({tag, "_fv"}, 32'(fill_valid), 0);
    chk({tag, "_faddr"}, 32'(fill_addr), 0);
    chk({tag, "_fdata"}, 32'(fill_data), 0);
    chk({tag, "_cnt"}, 32'(miss_cnt), 0);
  endtask

  initial begin
    #2 chk_idle_zero("rst_high");
    @(negedge clk);
    rst = 0;
    tick;
    chk_idle_zero("post_rst");
    miss_req  = 1;
    miss_addr = 16'h1234;
    for (int c = 0; c <= 18; c++) begin
      tick;
      miss_addr = c >= 2 ? 16'h0080 : 16'h1234;
      miss_req  = c <= 9;
      mem_idata = c == 7 ? 16'hABCD : (c == 17 ? 16'h5A5A : 16'h0000);
      chk($sformatf("t2_busy_c%0d", c), 32'(busy), 32'(c != 9));
      chk($sformatf("t2_iaddr_c%0d", c), 32'(mem_iaddr), c <= 8 ? 32'h1234 : (c == 9 ? 32'h0 : 32'h0080));
      chk($sformatf("t2_fv_c%0d", c), 32'(fill_valid), 32'(c == 8 || c == 18));
      chk($sformatf("t2_faddr_c%0d", c), 32'(fill_addr), c < 8 ? 32'h0 : (c < 18 ? 32'h1234 : 32'h0080));
      chk($sformatf("t2_fdata_c%0d", c), 32'(fill_data), c < 8 ? 32'h0 : (c < 18 ? 32'hABCD : 32'h5A5A));
      chk($sformatf("t2_cnt_c%0d", c), 32'(miss_cnt), c <= 9 ? 32'd1 : 32'd2);
    end
    tick;
    chk("t3_idle_busy", 32'(busy), 0);
    chk("t3_idle_fdata_hold", 32'(fill_data), 32'h5A5A);
    miss_req  = 1;
    miss_addr = 16'h0300;
    for (int r = 0; r <= 11; r++) begin
      tick;
      miss_req  = 0;
      gwe       = !(r >= 4 && r <= 6);
      mem_idata = r == 10 ? 16'h1111 : 16'hFFFF;
      chk($sformatf("t4_busy_r%0d", r), 32'(busy), 1);
      chk($sformatf("t4_iaddr_r%0d", r), 32'(mem_iaddr), 32'h0300);
      chk($sformatf("t4_fv_r%0d", r), 32'(fill_valid), 32'(r == 11));
      chk($sformatf("t4_cnt_r%0d", r), 32'(miss_cnt), 3);
    end
    chk("t4_faddr", 32'(fill_addr), 32'h0300);
    chk("t4_fdata", 32'(fill_data), 32'h1111);
    gwe = 0;
    #1 chk("t4_fill_frozen_fv", 32'(fill_valid), 0);
    tick;
    chk("t4_fill_frozen_busy", 32'(busy), 1);
    chk("t4_fill_frozen_fv2", 32'(fill_valid), 0);
    gwe = 1;
    #1 chk("t4_fill_resume_fv", 32'(fill_valid), 1);
    tick;
    chk("t4_done_busy", 32'(busy), 0);
    miss_req  = 1;
    miss_addr = 16'h0400;
    tick;
    miss_req = 0;
    tick;
    tick;
    tick;
    chk("t1_wait3_busy", 32'(busy), 1);
    chk("t1_wait3_cnt", 32'(miss_cnt), 4);
    #2 rst = 1;
    #1 chk("t1_rst_busy", 32'(busy), 0);
    chk("t1_rst_iaddr", 32'(mem_iaddr), 0);
    chk("t1_rst_cnt", 32'(miss_cnt), 0);
    chk("t1_rst_cnt_s", 32'(miss_cnt_s), 0);
    #1 rst = 0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      pulses += int'(fill_valid);
      chk($sformatf("t1_after_busy_c%0d", c), 32'(busy), 0);
    end
    chk("t1_no_fill", 32'(pulses), 0);
    miss_req  = 1;
    miss_addr = 16'h0555;
    mem_idata = 16'h7777;
    pulses    = 0;
    for (int c = 0; c < 90; c++) begin
      tick;
      if (fill_valid) begin
        pulses++;
        chk($sformatf("t5_faddr_c%0d", c), 32'(fill_addr), 32'h0555);
        chk($sformatf("t5_fdata_c%0d", c), 32'(fill_data), 32'h7777);
      end
      chk($sformatf("t5_busy_c%0d", c), 32'(busy), 32'(c % 10 != 9));
      chk($sformatf("t5_fv_c%0d", c), 32'(fill_valid), 32'(c % 10 == 8));
      if (c % 10 == 0) begin
        chk($sformatf("t5_cnt_c%0d", c), 32'(miss_cnt), 32'(c / 10 + 1));
        chk($sformatf("t6_cnt_s_c%0d", c), 32'(miss_cnt_s), c / 10 + 1 < 7 ? 32'(c / 10 + 1) : 32'd7);
      end
    end
    chk("t5_pulses", 32'(pulses), 9);
    chk("t6_sat_final", 32'(miss_cnt_s), 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
